score_seg_scanner: RTL and testbench
====================================

SCORE_SEG_SCANNER -- requirements
Module: score_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, SHALL set the clk_100MHz cycles each digit is shown (1 kHz digit rate).
REQ-002 Parameter GUARD_CYCLES, default 8, SHALL set the anode-off cycles at the start of each digit slot (anti-ghosting); it SHALL be less than REFRESH_DIV.
REQ-003 Parameter BLINK_FRAMES, default 30, SHALL set the frame ticks per blink half-period.
REQ-004 clk_100MHz  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 dig0, dig1, dig2, dig3  input  4 each  BCD score digits: dig1:dig0 is player 1 (tens:units), dig3:dig2 is player 2.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame, asserted when x==0 and y==0.
REQ-008 blink_en  input  1  level; when high the display SHALL blink (game-over indication).
REQ-009 blank_lz  input  1  level; when high, leading-zero tens digits SHALL be blanked.
REQ-010 segments  output  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}; registered.
REQ-011 anodes  output  4  active-low digit enables, with bit n selecting digit n; registered.

Function
REQ-012 Shadow registers SHALL capture dig0..dig3 on each cycle with frame_tick=1; only the shadow values SHALL be displayed (no mid-frame tearing).
REQ-013 The slot counter SHALL count 0..REFRESH_DIV-1 and wrap; at the wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-014 While the slot counter is below GUARD_CYCLES, anodes SHALL be 4'b1111.
REQ-015 Otherwise, anodes SHALL be ~(4'b0001 << index).
REQ-016 Decode SHALL follow standard 0-9 patterns: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
REQ-017 Digit values 10-15 SHALL decode to a dash, 7'b0111111 (g segment only).
REQ-018 When blank_lz=1 and the displayed index is 1 or 3 with a shadow value of 0, segments SHALL be 7'b1111111.
REQ-019 The blink phase SHALL toggle every BLINK_FRAMES frame ticks while blink_en=1.
REQ-020 While blink_en=1 and the blink phase is off, anodes SHALL be 4'b1111 regardless of the slot position.
REQ-021 When blink_en=0, the blink phase SHALL be forced on and its frame counter cleared within 1 cycle.
REQ-022 segments and anodes SHALL reflect the index and counter values of the previous cycle (1-cycle registered latency).
REQ-023 A frame_tick that coincides with a slot wrap SHALL both capture the shadows and advance the index; the new index SHALL display the new shadow value.
REQ-024 A frame_tick that coincides with a blink-counter terminal count SHALL toggle the blink phase exactly once.

Reset
REQ-025 Asserting reset SHALL immediately force: anodes=4'b1111, segments=7'b1111111, index=0, slot counter=0, shadows=0, blink phase on, blink counter=0.
REQ-026 After reset is released, the first visible digit SHALL be digit 0, enabled GUARD_CYCLES+1 cycles after release.
REQ-027 Asserting reset mid-slot or mid-blink SHALL abandon all in-progress state without glitching anodes low.

Structure
REQ-028 A shared package SHALL hold the 16-entry segment encoding constants, the blank and dash patterns, the anode-off constant, and the default parameter values.
REQ-029 One combinational sub-module, seg_decoder (4-bit value plus blank flag in, 7-bit segments out), SHALL perform the digit decode.
REQ-030 The counters, shadow registers, blink logic and output registers SHALL reside in score_seg_scanner.

Verification (bench uses REFRESH_DIV=6, GUARD_CYCLES=1, BLINK_FRAMES=2)
REQ-031 Scan: digits 1,2,3,4 with one frame_tick, blink_en=0, blank_lz=0 -> anodes cycle 1110,1101,1011,0111 with segments 1111001,0100100,0110000,0011001, each held 5 cycles after a 1-cycle 1111 guard.
REQ-032 No tearing: change dig0 from 1 to 7 mid-frame -> digit 0 still shows 1111001 until the next frame_tick, then 1111000.
REQ-033 Blanking: blank_lz=1 with dig1=0, dig3=0, dig0=5, dig2=9 -> index 1 and index 3 slots show 1111111; digit 0 shows 0010010 and digit 2 shows 0010000.
REQ-034 Invalid digit: dig2=4'hC -> index 2 slot shows 0111111.
REQ-035 Blink: blink_en=1 with 4 frame_ticks -> anodes all 1111 for frame ticks 2-3 and scanning resumes after tick 4; dropping blink_en mid-off-phase restores scanning within 2 cycles.
REQ-036 Async reset: assert reset mid-slot between clock edges -> anodes=1111 and segments=1111111 before the next clock edge; on release, index-0 scanning restarts.

Source files
------------

// File: rtl/score_seg_scanner_pkg.sv
// rtl/score_seg_scanner_pkg.sv - shared constants for the score 7-segment scanner
package score_seg_scanner_pkg;

    localparam int DEFAULT_REFRESH_DIV  = 100000;
    localparam int DEFAULT_GUARD_CYCLES = 8;
    localparam int DEFAULT_BLINK_FRAMES = 30;

    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; entry n is the pattern for value n, 10-15 show a dash
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/score_seg_scanner_seg_decoder.sv
// rtl/score_seg_scanner_seg_decoder.sv - combinational BCD to active-low 7-segment decode
module seg_decoder
    import score_seg_scanner_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_TABLE[value];
        if (blank) begin
            segments = SEG_BLANK;
        end
    end

endmodule

// File: rtl/score_seg_scanner.sv
// rtl/score_seg_scanner.sv - four-digit multiplexed score display with guard, blanking and blink
module score_seg_scanner
    import score_seg_scanner_pkg::*;
#(
    parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
    parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
    parameter int BLINK_FRAMES = DEFAULT_BLINK_FRAMES
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    input  logic [3:0] dig3,
    input  logic       frame_tick,
    input  logic       blink_en,
    input  logic       blank_lz,
    output logic [6:0] segments,
    output logic [3:0] anodes
);

    localparam int CNT_W   = $clog2(REFRESH_DIV);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   GUARD_VAL  = CNT_W'(GUARD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]   slot_cnt;
    logic [1:0]         index;
    logic [3:0][3:0]    shadow;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    logic [3:0] cur_val;
    logic       cur_blank;
    logic [6:0] seg_next;
    logic [3:0] anodes_next;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            index    <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            index    <= index + 2'd1;
        end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
        end
    end

    // Shadows freeze the score for a whole frame so a digit never changes mid-scan
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (frame_tick) begin
            shadow <= {dig3, dig2, dig1, dig0};
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            blink_on  <= 1'b1;
            blink_cnt <= '0;
        end else if (!blink_en) begin
            blink_on  <= 1'b1;
            blink_cnt <= '0;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_on  <= ~blink_on;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        cur_val   = shadow[index];
        cur_blank = blank_lz && index[0] && (cur_val == 4'd0);
    end

    seg_decoder u_seg_decoder (
        .value    (cur_val),
        .blank    (cur_blank),
        .segments (seg_next)
    );

    // blink_on is only ever low while blink_en is high, so it alone gates the anodes
    always_comb begin
        anodes_next = ~(4'b0001 << index);
        if ((slot_cnt < GUARD_VAL) || !blink_on) begin
            anodes_next = ANODES_OFF;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            anodes   <= ANODES_OFF;
            segments <= SEG_BLANK;
        end else begin
            anodes   <= anodes_next;
            segments <= seg_next;
        end
    end

endmodule

// File: tb/tb_score_seg_scanner.sv
// tb/tb_score_seg_scanner.sv - scoreboard bench for score_seg_scanner with short refresh/blink periods
module tb_score_seg_scanner;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [3:0] OFF   = 4'b1111;

    logic       clk_100MHz;
    logic       reset;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic       frame_tick;
    logic       blink_en;
    logic       blank_lz;
    logic [6:0] segments;
    logic [3:0] anodes;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         tick;
        int         mode;
        logic [3:0] an;
        logic [6:0] seg;
        string      tag;
    } exp_t;

    exp_t sb[$];

    score_seg_scanner #(
        .REFRESH_DIV  (6),
        .GUARD_CYCLES (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .frame_tick (frame_tick),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .segments   (segments),
        .anodes     (anodes)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [3:0] an_of(input int idx);
        logic [3:0] t [4];
        t = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        return t[idx];
    endfunction

    task automatic push(input bit tick, input int mode, input logic [3:0] an,
                        input logic [6:0] seg, input string tag);
        exp_t e;
        e.tick = tick;
        e.mode = mode;
        e.an   = an;
        e.seg  = seg;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic push_slot(input int idx, input logic [6:0] seg, input bit tick, input string tag);
        push(tick, 1, OFF, BLANK, {tag, "_guard"});
        repeat (5) push(1'b0, 2, an_of(idx), seg, tag);
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                              input logic [6:0] s3, input bit tick, input string tag);
        push_slot(0, s0, tick, {tag, "_d0"});
        push_slot(1, s1, 1'b0, {tag, "_d1"});
        push_slot(2, s2, 1'b0, {tag, "_d2"});
        push_slot(3, s3, 1'b0, {tag, "_d3"});
    endtask

    task automatic push_off(input int n, input bit tick, input string tag);
        push(tick, 1, OFF, BLANK, tag);
        repeat (n - 1) push(1'b0, 1, OFF, BLANK, tag);
    endtask

    task automatic run_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            frame_tick = e.tick;
            @(posedge clk_100MHz);
            #1;
            frame_tick = 1'b0;
            if (e.mode == 2) begin
                checks++;
                assert ({anodes, segments} === {e.an, e.seg}) else begin
                    errors++;
                    $error("FAIL %s: anodes/segments got %b/%b expected %b/%b",
                           e.tag, anodes, segments, e.an, e.seg);
                end
            end else if (e.mode == 1) begin
                checks++;
                assert (anodes === e.an) else begin
                    errors++;
                    $error("FAIL %s: anodes got %b expected %b", e.tag, anodes, e.an);
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        frame_tick = 1'b0;
        blink_en = 1'b0;
        blank_lz = 1'b0;
        dig0 = 4'd1; dig1 = 4'd2; dig2 = 4'd3; dig3 = 4'd4;

        repeat (2) @(posedge clk_100MHz);
        #1;
        checks++;
        assert ({anodes, segments} === {OFF, BLANK}) else begin
            errors++;
            $error("FAIL reset_outputs: got %b/%b expected %b/%b", anodes, segments, OFF, BLANK);
        end
        reset = 1'b0;

        // Scan order after a single frame tick
        push_frame(S1, S2, S3, S4, 1'b1, "scan");
        run_sb();

        // New dig0 is held off until the next frame tick
        dig0 = 4'd7;
        push_frame(S1, S2, S3, S4, 1'b0, "tear_old");
        push_frame(S7, S2, S3, S4, 1'b1, "tear_new");
        run_sb();

        // Frame tick landing on the wrap edge
        dig0 = 4'd8;
        push_frame(S7, S2, S3, S4, 1'b0, "wrap_old");
        e = sb.pop_back();
        e.tick = 1'b1;
        sb.push_back(e);
        push_frame(S8, S2, S3, S4, 1'b0, "wrap_new");
        run_sb();

        blank_lz = 1'b1;
        dig0 = 4'd5; dig1 = 4'd0; dig2 = 4'd9; dig3 = 4'd0;
        push_frame(S5, BLANK, S9, BLANK, 1'b1, "blank_lz");
        run_sb();

        blank_lz = 1'b0;
        dig2 = 4'hC;
        push_frame(S5, S0, DASH, S0, 1'b1, "invalid");
        run_sb();

        blink_en = 1'b1;
        push_frame(S5, S0, DASH, S0, 1'b1, "blink_t1");
        push_off(24, 1'b1, "blink_t2_off");
        push_off(24, 1'b1, "blink_t3_off");
        push_frame(S5, S0, DASH, S0, 1'b1, "blink_t4");
        push_frame(S5, S0, DASH, S0, 1'b1, "blink_t5");
        push_off(14, 1'b1, "blink_t6_off");
        run_sb();

        blink_en = 1'b0;
        push(1'b0, 0, OFF, BLANK, "blink_drop_settle");
        repeat (3) push(1'b0, 2, an_of(2), DASH, "blink_drop");
        push_slot(3, S0, 1'b0, "blink_drop_d3");
        run_sb();

        push_slot(0, S5, 1'b0, "pre_reset");
        repeat (3) void'(sb.pop_back());
        run_sb();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        assert ({anodes, segments} === {OFF, BLANK}) else begin
            errors++;
            $error("FAIL async_reset: got %b/%b expected %b/%b", anodes, segments, OFF, BLANK);
        end
        @(posedge clk_100MHz);
        #1;
        reset = 1'b0;
        push_frame(S0, S0, S0, S0, 1'b0, "post_reset");
        run_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
